// File: rtl/vertex_rotate_sequencer_pkg.sv
// Shared constants, record field layout and FSM state type for the vertex
// rotate sequencer.
package vrs_pkg;

    localparam int CENTER  = 1280;
    localparam int FRAC    = 7;
    localparam int CNT_W   = 8;
    localparam int REC_W   = 224;
    localparam int COORD_W = 12;
    localparam int COEF_W  = 8;

    localparam int X1_HI      = 215;
    localparam int X1_LO      = 204;
    localparam int X2_HI      = 203;
    localparam int X2_LO      = 192;
    localparam int X3_HI      = 191;
    localparam int X3_LO      = 180;
    localparam int PAYLOAD_HI = 179;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        MUL1,
        MUL2,
        MUL3,
        PUSH
    } state_e;

endpackage

// File: rtl/vertex_rotate_sequencer_if.sv
// Bus bundle between the vertex buffer, the sequencer and the PreCalc FIFO.
// The master modport is the sequencer's view; slave is its environment.
interface vertex_rotate_sequencer_if;
    import vrs_pkg::*;

    logic                nextFrame;
    logic [COEF_W-1:0]   sin;
    logic [REC_W-1:0]    VertexBuffer_PreCalc_ReadData;
    logic                VertexBuffer_PreCalc_empty;
    logic                VertexBuffer_PreCalc_pop;
    logic [REC_W-1:0]    PreCalc_TriangleFIFO_WriteData;
    logic                PreCalc_TriangleFIFO_push;
    logic                PreCalc_TriangleFIFO_wait;
    logic                busy;
    logic [CNT_W-1:0]    tri_count;

    modport master (
        input  nextFrame,
        input  sin,
        input  VertexBuffer_PreCalc_ReadData,
        input  VertexBuffer_PreCalc_empty,
        output VertexBuffer_PreCalc_pop,
        output PreCalc_TriangleFIFO_WriteData,
        output PreCalc_TriangleFIFO_push,
        input  PreCalc_TriangleFIFO_wait,
        output busy,
        output tri_count
    );

    modport slave (
        output nextFrame,
        output sin,
        output VertexBuffer_PreCalc_ReadData,
        output VertexBuffer_PreCalc_empty,
        input  VertexBuffer_PreCalc_pop,
        input  PreCalc_TriangleFIFO_WriteData,
        input  PreCalc_TriangleFIFO_push,
        output PreCalc_TriangleFIFO_wait,
        input  busy,
        input  tri_count
    );

endinterface

// File: rtl/vertex_rotate_sequencer_rotate_mac.sv
// Rotates one 12-bit x coordinate about CENTER by a signed Q1.7 coefficient.
// Purely combinational; the sequencer time-shares a single instance.
module vrs_rotate_mac
    import vrs_pkg::*;
(
    input  logic        [COORD_W-1:0] x_i,
    input  logic signed [COEF_W-1:0]  coef_i,
    output logic        [COORD_W-1:0] r_o
);

    logic signed [COORD_W:0] d;
    logic signed [20:0]      p;

    assign d = $signed({1'b0, x_i}) - $signed((COORD_W+1)'(CENTER));
    assign p = 21'(d) * 21'(coef_i);

    // Arithmetic shift floors toward -inf; wrap back into screen space mod 2^12.
    assign r_o = 12'(p >>> FRAC) + 12'(CENTER);

endmodule

// File: rtl/vertex_rotate_sequencer.sv
// Drains vertex records, rotates x1/x2/x3 through one shared multiplier
// under a six-state FSM, and pushes the rotated record to the PreCalc FIFO.
module vertex_rotate_sequencer
    import vrs_pkg::*;
(
    input  logic                     clk100,
    input  logic                     reset_n,
    vertex_rotate_sequencer_if.master bus
);

    state_e                    state_q, state_d;
    logic        [X1_HI:0]     rec_q;
    logic        [COORD_W-1:0] r1_q, r2_q, r3_q;
    logic signed [COEF_W-1:0]  coef_q;
    logic        [CNT_W-1:0]   cnt_q;

    logic [COORD_W-1:0] mac_x, mac_r;
    logic               pop_fire, push_fire;
    logic               unused_rec_top;

    // The top byte of an input record is never forwarded; the output forces it to zero.
    assign unused_rec_top = ^bus.VertexBuffer_PreCalc_ReadData[REC_W-1:X1_HI+1];

    assign pop_fire  = (state_q == LATCH) && !bus.VertexBuffer_PreCalc_empty && !bus.nextFrame;
    assign push_fire = (state_q == PUSH) && !bus.PreCalc_TriangleFIFO_wait && !bus.nextFrame;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.VertexBuffer_PreCalc_empty) state_d = LATCH;
            LATCH:   state_d = bus.VertexBuffer_PreCalc_empty ? IDLE : MUL1;
            MUL1:    state_d = MUL2;
            MUL2:    state_d = MUL3;
            MUL3:    state_d = PUSH;
            PUSH:    if (!bus.PreCalc_TriangleFIFO_wait) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.nextFrame) state_d = IDLE;
    end

    always_comb begin
        mac_x = rec_q[X1_HI:X1_LO];
        case (state_q)
            MUL2:    mac_x = rec_q[X2_HI:X2_LO];
            MUL3:    mac_x = rec_q[X3_HI:X3_LO];
            default: mac_x = rec_q[X1_HI:X1_LO];
        endcase
    end

    vrs_rotate_mac u_mac (
        .x_i    (mac_x),
        .coef_i (coef_q),
        .r_o    (mac_r)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            // NOTE: the record and result registers are reset because they
            // drive WriteData, which must read zero straight out of reset.
            rec_q   <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            coef_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (bus.nextFrame) coef_q <= $signed(bus.sin);
            if (pop_fire) rec_q <= bus.VertexBuffer_PreCalc_ReadData[X1_HI:0];
            case (state_q)
                MUL1:    r1_q <= mac_r;
                MUL2:    r2_q <= mac_r;
                MUL3:    r3_q <= mac_r;
                default: ;
            endcase
            if (bus.nextFrame) begin
                cnt_q <= '0;
            end else if (push_fire && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.VertexBuffer_PreCalc_pop      = pop_fire;
    assign bus.PreCalc_TriangleFIFO_push     = push_fire;
    assign bus.PreCalc_TriangleFIFO_WriteData = {8'h00, r1_q, r2_q, r3_q, rec_q[PAYLOAD_HI:0]};
    assign bus.busy                          = (state_q != IDLE);
    assign bus.tri_count                     = cnt_q;

endmodule

// File: tb/tb_vertex_rotate_sequencer.sv
// Directed-plus-random bench: a queue-backed vertex buffer feeds the sequencer
// and a scoreboard built from the rotation rules checks every pushed record.
module tb_vertex_rotate_sequencer;
    import vrs_pkg::*;

    logic clk100 = 1'b0;
    logic reset_n;
    always #5 clk100 = ~clk100;

    vertex_rotate_sequencer_if bus ();

    vertex_rotate_sequencer dut (
        .clk100  (clk100),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rotation: floor((x-CENTER)*coef / 128) + CENTER, wrapped to 12 bits.
    function automatic logic [11:0] rot(input logic [11:0] x, input int coef);
        int d, p, q;
        d = int'(x) - 1280;
        p = d * coef;
        q = p / 128;
        if (p < 0 && (p % 128) != 0) q = q - 1;
        return 12'((((1280 + q) % 4096) + 4096) % 4096);
    endfunction

    function automatic logic [223:0] expect_word(input logic [223:0] rec, input int coef);
        return {8'h00, rot(rec[215:204], coef), rot(rec[203:192], coef),
                rot(rec[191:180], coef), rec[179:0]};
    endfunction

    function automatic logic [223:0] make_rec(input logic [11:0] x1, input logic [11:0] x2,
                                              input logic [11:0] x3);
        logic [191:0] pl;
        for (int i = 0; i < 6; i++) pl[i*32 +: 32] = $urandom;
        return {8'($urandom), x1, x2, x3, pl[179:0]};
    endfunction

    // Vertex buffer model: head record presented while non-empty.
    logic [223:0] vb_q[$];
    always @(posedge clk100) begin
        #1;
        bus.VertexBuffer_PreCalc_ReadData = (vb_q.size() > 0) ? vb_q[0] : '0;
        bus.VertexBuffer_PreCalc_empty    = (vb_q.size() == 0);
    end

    // Scoreboard / monitor, sampled on the falling edge.
    int           push_cnt  = 0;
    int           pop_cnt   = 0;
    int           cyc       = 0;
    int           model_cnt = 0;
    int           tb_coef   = 0;
    int           push_cyc[$];
    logic [223:0] exp_q[$];
    logic [223:0] last_push;

    always @(negedge clk100) begin
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
            model_cnt = 0;
            tb_coef   = 0;
        end else begin
            if (bus.nextFrame) begin
                check("push_on_frame", bus.PreCalc_TriangleFIFO_push, 0);
                exp_q.delete();
                model_cnt = 0;
                tb_coef   = int'($signed(bus.sin));
            end
            if (bus.VertexBuffer_PreCalc_pop) begin
                pop_cnt++;
                check("pop_vs_empty", vb_q.size() == 0, 0);
                check("pop_vs_push", bus.PreCalc_TriangleFIFO_push, 0);
                if (vb_q.size() > 0) exp_q.push_back(expect_word(vb_q.pop_front(), tb_coef));
            end
            if (bus.PreCalc_TriangleFIFO_push) begin
                push_cnt++;
                push_cyc.push_back(cyc);
                last_push = bus.PreCalc_TriangleFIFO_WriteData;
                check("push_vs_wait", bus.PreCalc_TriangleFIFO_wait, 0);
                check("tri_count", bus.tri_count, model_cnt);
                if (exp_q.size() > 0) check("push_data", bus.PreCalc_TriangleFIFO_WriteData, exp_q.pop_front());
                else check("push_data", bus.PreCalc_TriangleFIFO_WriteData, {256{1'b1}});
                if (model_cnt < 255) model_cnt++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    task automatic frame(input logic [7:0] s);
        bus.sin       = s;
        bus.nextFrame = 1'b1;
        tick();
        bus.nextFrame = 1'b0;
    endtask

    task automatic wait_push(input int target, input int budget);
        int n = 0;
        while (push_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("push_count", push_cnt, target);
    endtask

    task automatic wait_pop(input int target, input int budget);
        int n = 0;
        while (pop_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("pop_count", pop_cnt, target);
    endtask

    initial begin
        logic [223:0] rec;
        logic [223:0] recs[3];
        logic [223:0] expw;
        logic [7:0]   s;
        int           base_push, base_pop;

        reset_n                       = 1'b0;
        bus.nextFrame                 = 1'b0;
        bus.sin                       = '0;
        bus.PreCalc_TriangleFIFO_wait = 1'b0;
        #7;
        check("rst_pop", bus.VertexBuffer_PreCalc_pop, 0);
        check("rst_push", bus.PreCalc_TriangleFIFO_push, 0);
        check("rst_wdata", bus.PreCalc_TriangleFIFO_WriteData, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.tri_count, 0);
        tick(2);
        reset_n = 1'b1;
        tick();

        // Single record, coefficient 0.5.
        frame(8'd64);
        rec = make_rec(12'd1536, 12'd0, 12'd1280);
        vb_q.push_back(rec);
        wait_push(1, 40);
        check("t1_xfields", last_push[215:180], {12'd1408, 12'd640, 12'd1280});
        check("t1_payload", last_push[179:0], rec[179:0]);
        check("t1_top", last_push[223:216], 0);
        tick();
        check("t1_count", bus.tri_count, 1);

        // Coefficient extremes and pivot invariance.
        frame(8'h80);
        base_push = push_cnt;
        vb_q.push_back(make_rec(12'd1536, 12'($urandom), 12'($urandom)));
        wait_push(base_push + 1, 40);
        check("neg128_r1", last_push[215:204], 12'd1024);
        frame(8'd127);
        base_push = push_cnt;
        vb_q.push_back(make_rec(12'd1280, 12'($urandom), 12'($urandom)));
        wait_push(base_push + 1, 40);
        check("pivot_r1", last_push[215:204], 12'd1280);

        // Back-to-back records: one push every six cycles.
        frame(8'($urandom));
        base_push = push_cnt;
        push_cyc.delete();
        for (int i = 0; i < 4; i++) vb_q.push_back(make_rec(12'($urandom), 12'($urandom), 12'($urandom)));
        wait_push(base_push + 4, 60);
        for (int i = 1; i < 4; i++) check("push_spacing", push_cyc[i] - push_cyc[i-1], 6);

        // Random records under random FIFO back-pressure.
        frame(8'($urandom));
        base_push = push_cnt;
        for (int i = 0; i < 20; i++) vb_q.push_back(make_rec(12'($urandom), 12'($urandom), 12'($urandom)));
        for (int n = 0; n < 800 && push_cnt < base_push + 20; n++) begin
            bus.PreCalc_TriangleFIFO_wait = ($urandom_range(0, 3) == 0);
            tick();
        end
        bus.PreCalc_TriangleFIFO_wait = 1'b0;
        check("random_pushes", push_cnt, base_push + 20);

        // Wait held high at first PUSH: no push, WriteData stable.
        s = 8'($urandom_range(1, 127));
        frame(s);
        base_push = push_cnt;
        base_pop  = pop_cnt;
        bus.PreCalc_TriangleFIFO_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            recs[i] = make_rec(12'($urandom), 12'($urandom), 12'($urandom));
            vb_q.push_back(recs[i]);
        end
        expw = expect_word(recs[0], int'($signed(s)));
        wait_pop(base_pop + 1, 20);
        tick(3);
        for (int i = 0; i < 10; i++) begin
            check("hold_push", bus.PreCalc_TriangleFIFO_push, 0);
            check("hold_wdata", bus.PreCalc_TriangleFIFO_WriteData, expw);
            tick();
        end
        bus.PreCalc_TriangleFIFO_wait = 1'b0;
        wait_push(base_push + 3, 40);
        tick(20);
        check("pop_total", pop_cnt, base_pop + 3);

        // nextFrame during MUL2 aborts the record; new coefficient applies next.
        frame(8'd64);
        base_push = push_cnt;
        base_pop  = pop_cnt;
        vb_q.push_back(make_rec(12'($urandom), 12'($urandom), 12'($urandom)));
        wait_pop(base_pop + 1, 20);
        tick();
        s             = 8'($urandom_range(128, 255));
        bus.sin       = s;
        bus.nextFrame = 1'b1;
        tick();
        bus.nextFrame = 1'b0;
        check("abort_busy", bus.busy, 0);
        tick(10);
        check("abort_no_push", push_cnt, base_push);
        rec = make_rec(12'($urandom), 12'($urandom), 12'($urandom));
        vb_q.push_back(rec);
        wait_push(base_push + 1, 40);
        check("abort_new_coef", last_push, expect_word(rec, int'($signed(s))));

        // Reset while stalled in PUSH.
        bus.PreCalc_TriangleFIFO_wait = 1'b1;
        base_pop = pop_cnt;
        vb_q.push_back(make_rec(12'($urandom), 12'($urandom), 12'($urandom)));
        wait_pop(base_pop + 1, 20);
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_push", bus.PreCalc_TriangleFIFO_push, 0);
        check("mrst_pop", bus.VertexBuffer_PreCalc_pop, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_count", bus.tri_count, 0);
        check("mrst_wdata", bus.PreCalc_TriangleFIFO_WriteData, 0);
        tick();
        reset_n = 1'b1;
        bus.PreCalc_TriangleFIFO_wait = 1'b0;
        base_push = push_cnt;
        tick(10);
        check("mrst_no_push", push_cnt, base_push);

        // Counter saturation and clear.
        frame(8'($urandom));
        base_push = push_cnt;
        for (int i = 0; i < 300; i++) vb_q.push_back(make_rec(12'($urandom), 12'($urandom), 12'($urandom)));
        wait_push(base_push + 300, 300 * 6 + 100);
        tick();
        check("sat_count", bus.tri_count, 255);
        frame(8'($urandom));
        check("clear_count", bus.tri_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
